raw_split_5_streams: RTL and testbench
======================================

# raw_split_5_streams

Serialises the 80-bit, 5-lane combined raw stream (16 bits data + 12 bits channel number per lane) back into the per-stream 32-bit bundle format, one lane per beat, with a one-hot stream number. It sits on `bus_clk` downstream of the FIR or any other 80-bit stage. It feeds consumers that expect SPI-style bundles: loopback test paths, per-stream recorders, and the spike-detect front end.

## Interface
Parameters:
- `LANES`, 5, number of 16-bit lanes in the combined word.
- `CH_W`, 12, channel-number width per lane.

Ports:
- `bus_clk` in 1: the single clock.
- `xike_reset` in 1: asynchronous, active-high reset.
- `comb_valid` in 1: combined word valid.
- `comb_ready` out 1: combined word accepted when high together with `comb_valid`.
- `comb_data` in 80: lane k data is `[16k+15:16k]`.
- `comb_ch` in 60: lane k channel is `[12k+11:12k]`.
- `lane_mask` in 5: lanes to emit; sampled only at word acceptance.
- `bundle_valid` out 1: output beat valid.
- `bundle_ready` in 1: downstream accepts the beat.
- `bundle_data` out 32: bits `[15:0]` data, `[28:17]` channel, bits 16 and 31:29 are zero.
- `bundle_streamno` out 5: one-hot lane index of the current beat; zero when `bundle_valid` is low.
- `word_cnt` out 32: number of combined words fully emitted or dropped; wraps at 2^32.

## Operation
- Holding registers capture `comb_data`, `comb_ch` and `lane_mask` (as `pending`) on each accepted word.
- State machine has two states.
  - **IDLE**: `comb_ready`=1, `bundle_valid`=0.
    - On accept with mask ≠ 0: go to EMIT with `cur` = lowest set bit of the mask.
    - On accept with mask = 0: the word is dropped, `word_cnt`+1, stay in IDLE.
  - **EMIT**: `bundle_valid`=1, `bundle_streamno`=`cur`, `bundle_data` is built from lane `cur` of the holding registers.
    - On `bundle_ready`: clear `cur` from `pending`.
    - If bits remain: `cur` = lowest remaining set bit, stay in EMIT.
    - If no bits remain: this is the last beat.
- Last-beat overlap: `comb_ready` = `bundle_ready` && last beat. On a simultaneous accept, the next word loads in the same cycle. EMIT is kept, or IDLE is entered if the new mask is 0, which also drops that word. Sustained throughput is one beat per cycle.
- `word_cnt` increments once per word, on its last-beat handshake or on its drop cycle. If both events fall in the same cycle, it increments by 2.
- Lanes are emitted in ascending order; masked lanes are skipped with no idle cycle.

## Timing
- Reset values:
  - `comb_ready`=0 while reset is asserted, then 1 from the first clock after deassertion.
  - `bundle_valid`=0, `bundle_data`=0, `bundle_streamno`=0, `word_cnt`=0, state IDLE, `pending`=0.
- Latency: word accepted at edge N → first beat valid after edge N, i.e. in cycle N+1.
- AXI-stream rules:
  - While `bundle_valid` is high without `bundle_ready`, `bundle_data` and `bundle_streamno` hold stable.
  - `bundle_valid` is not withdrawn.
- `comb_ready` never depends combinationally on `comb_valid`; it depends only on state and `bundle_ready`.
- Boundary conditions:
  - `lane_mask` = 5'b10000: single beat, which is also the last beat.
  - Full mask: 5 beats per word.
  - Backpressure on the last beat blocks the next word.
- Reset mid-operation: the asynchronous reset clears state at once. The partially emitted word is lost and not counted, and no beat is emitted after reset deasserts.

## Structure
- Shared package `xike_pkg` holds:
  - `LANES`, `CH_W`, `DATA_W`=16.
  - Bundle field offsets: `BND_DATA_LSB`=0, `BND_CH_LSB`=17.
  - State enum `split_state_t` {IDLE, EMIT}.
- One natural sub-module, `lowest_set_onehot`: purely combinational, 5-bit vector → one-hot of its lowest set bit (zero in → zero out). It is used for both the initial and the next `cur`.
- Everything else is one always block plus output muxing, roughly 150–250 lines.

## Test plan
- **Full mask, no backpressure**:
  - Stimulus: word with data lanes 0x1111..0x5555, ch 0..4, `bundle_ready`=1.
  - Response: five consecutive beats with streamno 00001→10000 and bundle = {3'b0, ch, 1'b0, data}; `word_cnt`=1.
- **Back-to-back words, full mask**:
  - Stimulus: 4 words.
  - Response: 20 beats with no gap; `comb_ready` pulses on beats 5, 10 and 15; `word_cnt`=4.
- **Sparse and zero masks**:
  - Stimulus: mask 10101, then mask 00000, then mask 00010.
  - Response: beats on lanes 0, 2, 4, then lane 1 only; the zero-mask word is dropped; `word_cnt`=3.
- **Random backpressure**:
  - Stimulus: `bundle_ready` toggling 30%.
  - Response: outputs stable while stalled, no beats lost or duplicated; scoreboard matches a reference model over 1000 words.
- **Reset mid-word**:
  - Stimulus: assert `xike_reset` after beat 2 of 5.
  - Response: all outputs return to reset values asynchronously; `word_cnt`=0; the first beat after reset comes from a newly accepted word.
- **Counter wrap**:
  - Stimulus: force `word_cnt` to 0xFFFFFFFF, then complete one word.
  - Response: `word_cnt`=0.

Source files
------------

// File: rtl/xike_pkg.sv
// Shared definitions for the combined-raw-stream splitter: lane geometry, bundle layout, FSM states.
// Pure declarations; no timing or backpressure behaviour of its own.
package xike_pkg;

  localparam int LANES        = 5;
  localparam int CH_W         = 12;
  localparam int DATA_W       = 16;
  localparam int BND_W        = 32;
  localparam int BND_DATA_LSB = 0;
  localparam int BND_CH_LSB   = 17;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } split_state_t;

  // Bit 16 and bits 31:29 stay zero.
  function automatic logic [BND_W-1:0] make_bundle(input logic [DATA_W-1:0] d,
                                                   input logic [CH_W-1:0]   ch);
    logic [BND_W-1:0] b;
    b = '0;
    b[BND_DATA_LSB +: DATA_W] = d;
    b[BND_CH_LSB +: CH_W]     = ch;
    return b;
  endfunction

endpackage

// File: rtl/raw_split_5_streams_lowest_set_onehot.sv
// One-hot of the lowest set bit of a vector (zero in gives zero out).
// Purely combinational: zero latency, no backpressure.
module lowest_set_onehot #(
  parameter int W = 5
) (
  input  logic [W-1:0] vec,
  output logic [W-1:0] onehot
);

  // Two's-complement trick isolates the least significant set bit.
  assign onehot = vec & (~vec + W'(1));

endmodule

// File: rtl/raw_split_5_streams.sv
// Splits an 80-bit 5-lane combined word into per-lane 32-bit bundles, ascending lane order, one per beat.
// First beat one cycle after acceptance; a new word is taken only with the last beat's handshake.
module raw_split_5_streams #(
  parameter int LANES = xike_pkg::LANES,
  parameter int CH_W  = xike_pkg::CH_W
) (
  input  logic                          bus_clk,
  input  logic                          xike_reset,
  input  logic                          comb_valid,
  output logic                          comb_ready,
  input  logic [LANES*16-1:0]           comb_data,
  input  logic [LANES*CH_W-1:0]         comb_ch,
  input  logic [LANES-1:0]              lane_mask,
  output logic                          bundle_valid,
  input  logic                          bundle_ready,
  output logic [31:0]                   bundle_data,
  output logic [LANES-1:0]              bundle_streamno,
  output logic [31:0]                   word_cnt
);

  import xike_pkg::*;

  split_state_t              state, state_nxt;
  logic [LANES*DATA_W-1:0]   data_q;
  logic [LANES*CH_W-1:0]     ch_q;
  logic [LANES-1:0]          pending, pending_nxt;
  logic [LANES-1:0]          cur, cur_nxt;
  logic [LANES-1:0]          remaining, first_cur, next_cur;
  logic [31:0]               cnt_q;
  logic [1:0]                cnt_inc;
  logic                      rdy_en;
  logic                      last_beat, beat_done, accept, load;
  logic [DATA_W-1:0]         sel_data;
  logic [CH_W-1:0]           sel_ch;

  assign remaining = pending & ~cur;
  assign last_beat = (remaining == '0);
  assign beat_done = (state == EMIT) && bundle_ready;

  // rdy_en keeps comb_ready low while reset is held and until the first clock after release.
  assign comb_ready = rdy_en && ((state == IDLE) || (beat_done && last_beat));
  assign accept     = comb_valid && comb_ready;

  lowest_set_onehot #(.W(LANES)) u_first (
    .vec    (lane_mask),
    .onehot (first_cur)
  );

  lowest_set_onehot #(.W(LANES)) u_next (
    .vec    (remaining),
    .onehot (next_cur)
  );

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    cur_nxt     = cur;
    load        = 1'b0;
    cnt_inc     = 2'd0;
    if (beat_done) begin
      if (!last_beat) begin
        pending_nxt = remaining;
        cur_nxt     = next_cur;
      end else begin
        state_nxt   = IDLE;
        pending_nxt = '0;
        cur_nxt     = '0;
        cnt_inc     = 2'd1;
      end
    end
    // A word accepted on the last beat overrides the return to IDLE.
    if (accept) begin
      load = 1'b1;
      if (lane_mask != '0) begin
        state_nxt   = EMIT;
        pending_nxt = lane_mask;
        cur_nxt     = first_cur;
      end else begin
        state_nxt   = IDLE;
        pending_nxt = '0;
        cur_nxt     = '0;
        cnt_inc     = cnt_inc + 2'd1;
      end
    end
  end

  always_ff @(posedge bus_clk or posedge xike_reset) begin
    if (xike_reset) begin
      state   <= IDLE;
      pending <= '0;
      cur     <= '0;
      cnt_q   <= '0;
      rdy_en  <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      cur     <= cur_nxt;
      cnt_q   <= cnt_q + 32'(cnt_inc);
      rdy_en  <= 1'b1;
      if (load) begin
        data_q <= comb_data;
        ch_q   <= comb_ch;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_ch   = '0;
    for (int k = 0; k < LANES; k++) begin
      if (cur[k]) begin
        sel_data = data_q[k*DATA_W +: DATA_W];
        sel_ch   = ch_q[k*CH_W +: CH_W];
      end
    end
  end

  assign bundle_valid    = (state == EMIT);
  assign bundle_streamno = bundle_valid ? cur : '0;
  assign bundle_data     = bundle_valid ? make_bundle(sel_data, sel_ch) : '0;
  assign word_cnt        = cnt_q;

endmodule

// File: tb/tb_raw_split_5_streams.sv
// Directed and random checks of raw_split_5_streams against a queue-based beat model.
module tb_raw_split_5_streams;

  typedef struct {
    logic [15:0] d;
    logic [11:0] ch;
    logic [4:0]  sno;
    bit          last;
  } beat_t;

  typedef struct {
    logic [79:0] d;
    logic [59:0] ch;
    logic [4:0]  m;
  } word_t;

  logic        bus_clk = 1'b0;
  logic        xike_reset = 1'b0;
  logic        comb_valid = 1'b0;
  logic        comb_ready;
  logic [79:0] comb_data = '0;
  logic [59:0] comb_ch = '0;
  logic [4:0]  lane_mask = '0;
  logic        bundle_valid;
  logic        bundle_ready = 1'b0;
  logic [31:0] bundle_data;
  logic [4:0]  bundle_streamno;
  logic [31:0] word_cnt;

  raw_split_5_streams dut (
    .bus_clk         (bus_clk),
    .xike_reset      (xike_reset),
    .comb_valid      (comb_valid),
    .comb_ready      (comb_ready),
    .comb_data       (comb_data),
    .comb_ch         (comb_ch),
    .lane_mask       (lane_mask),
    .bundle_valid    (bundle_valid),
    .bundle_ready    (bundle_ready),
    .bundle_data     (bundle_data),
    .bundle_streamno (bundle_streamno),
    .word_cnt        (word_cnt)
  );

  always #5 bus_clk = ~bus_clk;

  beat_t       exp_q[$];
  word_t       src_q[$];
  word_t       cur_word;
  logic [31:0] exp_cnt = '0;
  int          n_assert = 0;
  int          n_fail = 0;
  int          p_rdy = 100;
  int          p_valid = 100;
  int          cyc = 0;
  int          beats = 0;
  int          overlaps = 0;
  int          first_beat_cyc = -1;
  int          last_beat_cyc = -1;
  bit          stall_prev = 0;
  logic [31:0] prev_data = '0;
  logic [4:0]  prev_sno = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_word(input word_t w);
    int hi;
    hi = -1;
    for (int k = 0; k < 5; k++) if (w.m[k]) hi = k;
    if (hi < 0) exp_cnt++;
    for (int k = 0; k < 5; k++) begin
      if (w.m[k]) begin
        beat_t b;
        b.d    = w.d[16*k +: 16];
        b.ch   = w.ch[12*k +: 12];
        b.sno  = 5'(1 << k);
        b.last = (k == hi);
        exp_q.push_back(b);
      end
    end
  endfunction

  function automatic word_t rand_word();
    word_t w;
    for (int k = 0; k < 5; k++) begin
      w.d[16*k +: 16]  = 16'($urandom);
      w.ch[12*k +: 12] = 12'($urandom);
    end
    w.m = ($urandom_range(0, 9) == 0) ? 5'b0 : 5'($urandom);
    return w;
  endfunction

  function automatic word_t mk_word(input logic [4:0] m, input int seed);
    word_t w;
    for (int k = 0; k < 5; k++) begin
      w.d[16*k +: 16]  = 16'(16'h1111 * (k + 1) + seed);
      w.ch[12*k +: 12] = 12'(k + seed);
    end
    w.m = m;
    return w;
  endfunction

  // Sample at the falling edge, then advance past the rising edge and drive the next inputs.
  task automatic cycle();
    int  had;
    bit  acc;
    bit  exp_rdy;
    @(negedge bus_clk);
    cyc++;
    had = exp_q.size();
    exp_rdy = (had == 0) || (had == 1 && bundle_ready);
    chk("word_cnt", word_cnt, exp_cnt);
    chk("bundle_valid", 32'(bundle_valid), 32'(had != 0));
    chk("comb_ready", 32'(comb_ready), 32'(exp_rdy));
    if (!bundle_valid) begin
      chk("idle_streamno", 32'(bundle_streamno), 32'h0);
      chk("idle_data", bundle_data, 32'h0);
    end
    if (stall_prev) begin
      chk("stall_data", bundle_data, prev_data);
      chk("stall_streamno", 32'(bundle_streamno), 32'(prev_sno));
    end
    if (bundle_valid && bundle_ready && had > 0) begin
      beat_t b;
      b = exp_q.pop_front();
      chk("beat_data", bundle_data, {3'b000, b.ch, 1'b0, b.d});
      chk("beat_streamno", 32'(bundle_streamno), 32'(b.sno));
      if (b.last) exp_cnt++;
      beats++;
      if (first_beat_cyc < 0) first_beat_cyc = cyc;
      last_beat_cyc = cyc;
    end
    acc = comb_valid && comb_ready;
    if (acc) begin
      if (had > 0) overlaps++;
      push_word(cur_word);
    end
    stall_prev = bundle_valid && !bundle_ready;
    prev_data  = bundle_data;
    prev_sno   = bundle_streamno;
    @(posedge bus_clk);
    #1;
    if (acc || !comb_valid) begin
      comb_valid = 1'b0;
      if (src_q.size() > 0 && $urandom_range(0, 99) < p_valid) begin
        cur_word   = src_q.pop_front();
        comb_valid = 1'b1;
        comb_data  = cur_word.d;
        comb_ch    = cur_word.ch;
        lane_mask  = cur_word.m;
      end
    end
    bundle_ready = ($urandom_range(0, 99) < p_rdy);
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((src_q.size() > 0 || comb_valid || exp_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    n_assert++;
    assert (n < budget) else begin
      n_fail++;
      $error("FAIL timeout: observed %0d cycles expected fewer than %0d", n, budget);
    end
  endtask

  task automatic do_reset();
    xike_reset   = 1'b1;
    comb_valid   = 1'b0;
    bundle_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(bundle_valid), 32'h0);
    chk("rst_streamno", 32'(bundle_streamno), 32'h0);
    chk("rst_data", bundle_data, 32'h0);
    chk("rst_word_cnt", word_cnt, 32'h0);
    chk("rst_comb_ready", 32'(comb_ready), 32'h0);
    exp_q.delete();
    src_q.delete();
    exp_cnt        = '0;
    stall_prev     = 0;
    beats          = 0;
    overlaps       = 0;
    first_beat_cyc = -1;
    last_beat_cyc  = -1;
    repeat (2) @(posedge bus_clk);
    @(negedge bus_clk);
    chk("rst_hold_comb_ready", 32'(comb_ready), 32'h0);
    xike_reset = 1'b0;
    @(posedge bus_clk);
    #1;
  endtask

  initial begin
    int n;
    #2;
    do_reset();

    // Full mask, no backpressure.
    p_rdy = 100; p_valid = 100;
    src_q.push_back(mk_word(5'b11111, 0));
    run_idle(50);
    chk("full_word_cnt", word_cnt, 32'd1);
    chk("full_beats", beats, 5);
    chk("full_span", last_beat_cyc - first_beat_cyc + 1, 5);

    // Back-to-back full-mask words.
    do_reset();
    for (int i = 0; i < 4; i++) src_q.push_back(mk_word(5'b11111, 16 * i + 1));
    run_idle(100);
    chk("b2b_word_cnt", word_cnt, 32'd4);
    chk("b2b_span", last_beat_cyc - first_beat_cyc + 1, 20);
    chk("b2b_overlaps", overlaps, 3);

    // Sparse and zero masks.
    do_reset();
    src_q.push_back(mk_word(5'b10101, 7));
    src_q.push_back(mk_word(5'b00000, 9));
    src_q.push_back(mk_word(5'b00010, 11));
    run_idle(100);
    chk("sparse_word_cnt", word_cnt, 32'd3);
    chk("sparse_beats", beats, 4);

    // Backpressure on the single last beat blocks the next word.
    do_reset();
    src_q.push_back(mk_word(5'b10000, 3));
    src_q.push_back(mk_word(5'b10000, 5));
    p_rdy = 0;
    repeat (5) cycle();
    p_rdy = 100;
    run_idle(100);
    chk("single_word_cnt", word_cnt, 32'd2);

    // Random traffic and backpressure.
    do_reset();
    p_rdy = 70; p_valid = 80;
    for (int i = 0; i < 1000; i++) src_q.push_back(rand_word());
    run_idle(20000);

    // Reset after two beats of a full-mask word.
    do_reset();
    p_rdy = 100; p_valid = 100;
    src_q.push_back(mk_word(5'b11111, 40));
    n = 0;
    while (beats < 2 && n < 20) begin
      cycle();
      n++;
    end
    chk("mid_two_beats", beats, 2);
    #2;
    do_reset();
    repeat (3) cycle();
    src_q.push_back(mk_word(5'b01100, 50));
    run_idle(50);
    chk("post_rst_word_cnt", word_cnt, 32'd1);

    // Counter wrap.
    do_reset();
    force dut.cnt_q = 32'hFFFF_FFFF;
    @(posedge bus_clk);
    #1;
    release dut.cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    src_q.push_back(mk_word(5'b10000, 60));
    run_idle(50);
    chk("wrap_word_cnt", word_cnt, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
